// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the non-restoring divider.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package div_pkg;

  // Divider control states: waiting, iterating one bit per cycle, final fix-up.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_e;

  // Smallest operand width the datapath is built for.
  localparam int DIV_N_MIN = 4;

  // Iteration counter width for an N-bit divider: must be able to hold N.
  function automatic int div_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 non-restoring step: shift partial remainder, add/sub divisor, emit a quotient bit.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the step result is registered.
module div_step #(
  parameter int N = 32
) (
  input  logic [N:0]   p_i,  // partial remainder, two's complement, N+1 bits
  input  logic [N-1:0] q_i,  // remaining dividend bits (MSB first) / quotient bits so far
  input  logic [N-1:0] d_i,  // divisor magnitude
  output logic [N:0]   p_o,
  output logic [N-1:0] q_o
);

  logic [N:0] shifted;
  logic [N:0] d_ext;

  // Shift the next dividend bit into the partial remainder. The doubled value may
  // exceed N+1 bits, but the post-add/sub result always lands in [-D, D), so the
  // modulo-2^(N+1) arithmetic stays exact.
  assign shifted = {p_i[N-1:0], q_i[N-1]};
  assign d_ext   = {1'b0, d_i};

  // Non-negative remainder subtracts the divisor, negative remainder adds it back.
  assign p_o = p_i[N] ? (shifted + d_ext) : (shifted - d_ext);

  // Quotient bit is 1 when the new remainder is non-negative.
  assign q_o = {q_i[N-2:0], ~p_o[N]};

endmodule

// File: rtl/nonrestoring_divider.sv
// Iterative N-bit non-restoring divider; signed mode when DIVIDER_SIGNED_EN is defined.
// Latency: done pulses N+1 edges after the accepting edge; one new operand pair per N+2 cycles.
// Backpressure: start is only honoured in IDLE (busy=0); starts while busy are dropped, not queued.
module nonrestoring_divider
  import div_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         oClk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = div_cnt_w(N);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [N:0]    p_q;        // partial remainder
  logic [N-1:0]  q_q;        // dividend bits shifting out / quotient bits shifting in
  logic [N-1:0]  d_q;        // divisor magnitude
  logic          dbz_q;      // divisor was zero for the division in flight
  logic          busy_q;
  logic          done_q;
  logic [N-1:0]  quo_q;
  logic [N-1:0]  rem_q;
  logic          dbz_out_q;

  logic [N-1:0]  a_mag_d;
  logic [N-1:0]  b_mag_d;
  logic [N:0]    p_step;
  logic [N-1:0]  q_step;
  logic [N-1:0]  rem_mag;
  logic [N-1:0]  quo_d;
  logic [N-1:0]  rem_d;

`ifdef DIVIDER_SIGNED_EN
  logic a_neg_d, b_neg_d;
  logic a_neg_q, b_neg_q;

  // Split signed operands into sign and magnitude; |-2^(N-1)| still fits N unsigned bits.
  always_comb begin
    a_neg_d = dividend[N-1];
    b_neg_d = divisor[N-1];
    a_mag_d = a_neg_d ? -dividend : dividend;
    b_mag_d = b_neg_d ? -divisor  : divisor;
  end
`else
  // Unsigned operands are already magnitudes.
  always_comb begin
    a_mag_d = dividend;
    b_mag_d = divisor;
  end
`endif

  div_step #(.N(N)) u_step (
    .p_i (p_q),
    .q_i (q_q),
    .d_i (d_q),
    .p_o (p_step),
    .q_o (q_step)
  );

  // Final remainder restore, sign fix-up and divide-by-zero override.
  always_comb begin
    rem_mag = p_q[N] ? (p_q[N-1:0] + d_q) : p_q[N-1:0];
`ifdef DIVIDER_SIGNED_EN
    // Quotient truncates toward zero; remainder follows the dividend's sign.
    quo_d = (a_neg_q ^ b_neg_q) ? -q_q : q_q;
    rem_d = a_neg_q ? -rem_mag : rem_mag;
`else
    quo_d = q_q;
    rem_d = rem_mag;
`endif
    // With a zero divisor the iteration naturally leaves remainder = dividend;
    // only the quotient needs forcing to all ones.
    if (dbz_q) quo_d = '1;
  end

  // Control FSM plus datapath and result registers.
  always_ff @(posedge oClk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      p_q       <= '0;
      q_q       <= '0;
      d_q       <= '0;
      dbz_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
      dbz_out_q <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      a_neg_q   <= 1'b0;
      b_neg_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            p_q     <= '0;
            q_q     <= a_mag_d;
            d_q     <= b_mag_d;
            dbz_q   <= (divisor == '0);
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ITER;
`ifdef DIVIDER_SIGNED_EN
            a_neg_q <= a_neg_d;
            b_neg_q <= b_neg_d;
`endif
          end
        end
        ITER: begin
          p_q   <= p_step;
          q_q   <= q_step;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(N - 1)) state_q <= FIX;
        end
        FIX: begin
          quo_q     <= quo_d;
          rem_q     <= rem_d;
          dbz_out_q <= dbz_q;
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          cnt_q     <= '0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_out_q;

endmodule
